// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer and its registered ALU:
// operation codes, sequencer-only opcodes and FSM state encoding.
package alu_sequencer_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_INC = 4'h2;
   localparam logic [3:0] OP_DEC = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOP = 4'h7;
   localparam logic [3:0] OP_MOV = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_JC  = 4'hA;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Opcodes that run on the ALU and update the flags
   function automatic logic is_alu(input logic [3:0] op);
      return (op[3] == 1'b0) && (op != OP_NOP);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Three-cycle instruction sequencer driving an external registered ALU,
// with an inline 4-entry register file and a preload port.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [7:0]   instr,
   input  logic         ld_valid,
   output logic         ld_ready,
   input  logic [1:0]   ld_addr,
   input  logic [N-1:0] ld_data,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_op,
   input  logic [N-1:0] alu_result,
   input  logic         alu_carry,
   input  logic         alu_zero,
   output logic         wb_valid,
   output logic [1:0]   wb_addr,
   output logic [N-1:0] wb_data,
   output logic         flag_z,
   output logic         flag_c,
   output logic         branch_taken
);

   state_t state, state_nxt;

   logic [N-1:0] regs [4];
   logic [3:0]   op;
   logic [1:0]   rd;
   logic [1:0]   rs;
   logic         accept;
   logic         load;
   logic         writes;

   assign instr_ready = (state == S_IDLE);
   assign ld_ready    = (state == S_IDLE);
   assign accept      = instr_valid && instr_ready;
   assign load        = ld_valid && ld_ready;
   assign writes      = (state == S_WB) && (is_alu(op) || op == OP_MOV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (accept) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Preloads only happen in IDLE and writebacks only in WB, so they never collide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         op     <= OP_NOP;
         rd     <= 2'd0;
         rs     <= 2'd0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else begin
         if (accept) begin
            op <= instr[7:4];
            rd <= instr[3:2];
            rs <= instr[1:0];
         end
         if (load)   regs[ld_addr] <= ld_data;
         if (writes) regs[rd] <= alu_result;
         if (state == S_WB && is_alu(op)) begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
         end
      end
   end

   always_comb begin
      alu_op       = OP_NOP;
      alu_a        = '0;
      alu_b        = '0;
      wb_valid     = 1'b0;
      wb_addr      = 2'd0;
      wb_data      = '0;
      branch_taken = 1'b0;
      if (state == S_EXEC) begin
         if (is_alu(op)) begin
            alu_op = op;
            alu_a  = regs[rd];
            alu_b  = regs[rs];
         end else if (op == OP_MOV) begin
            alu_a = regs[rs];
         end
      end
      if (state == S_WB) begin
         wb_valid = writes;
         if (writes) begin
            wb_addr = rd;
            wb_data = alu_result;
         end
         branch_taken = (op == OP_JZ && flag_z) || (op == OP_JC && flag_c);
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered ALU
// (carry-out for ADD/INC, borrow for SUB, zero carry otherwise).
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [7:0]   instr = 8'h00;
   logic         ld_valid = 1'b0;
   logic         ld_ready;
   logic [1:0]   ld_addr = 2'd0;
   logic [N-1:0] ld_data = '0;
   logic [N-1:0] alu_a, alu_b;
   logic [3:0]   alu_op;
   logic [N-1:0] alu_result;
   logic         alu_carry, alu_zero;
   logic         wb_valid;
   logic [1:0]   wb_addr;
   logic [N-1:0] wb_data;
   logic         flag_z, flag_c, branch_taken;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .flag_z(flag_z), .flag_c(flag_c), .branch_taken(branch_taken)
   );

   // Registered ALU, one cycle latency
   always_ff @(posedge clk) begin
      logic [N:0] s;
      s = '0;
      unique case (alu_op)
         OP_ADD:  s = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB:  s = {1'b0, alu_a} - {1'b0, alu_b};
         OP_INC:  s = {1'b0, alu_a} + 1'b1;
         OP_DEC:  s = {1'b0, alu_a - 1'b1};
         OP_AND:  s = {1'b0, alu_a & alu_b};
         OP_OR:   s = {1'b0, alu_a | alu_b};
         OP_XOR:  s = {1'b0, alu_a ^ alu_b};
         default: s = {1'b0, alu_a};
      endcase
      alu_result <= s[N-1:0];
      alu_carry  <= s[N];
      alu_zero   <= (s[N-1:0] == '0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [7:0] mk(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s);
      return {o, d, s};
   endfunction

   task automatic preload(input logic [1:0] a, input logic [N-1:0] d);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic issue(input logic [7:0] w);
      instr_valid = 1'b1; instr = w;
      tick();
      instr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation ran past time limit");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      chk("rst_alu_op", alu_op, 4'h7);
      chk("rst_alu_a", alu_a, 8'h00);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_flags", {flag_z, flag_c}, 2'b00);
      chk("rst_branch", branch_taken, 1'b0);
      tick();
      rst = 1'b0;
      chk("rel_instr_ready", instr_ready, 1'b1);
      chk("rel_ld_ready", ld_ready, 1'b1);

      // ADD with carry: F0 + 20
      preload(2'd0, 8'hF0);
      preload(2'd1, 8'h20);
      issue(mk(OP_ADD, 2'd0, 2'd1));
      chk("add_exec_op", alu_op, OP_ADD);
      chk("add_exec_ab", {alu_a, alu_b}, 16'hF020);
      chk("add_exec_ready", {instr_ready, ld_ready}, 2'b00);
      // Ignored traffic while busy
      ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
      instr_valid = 1'b1; instr = 8'hF0;
      tick();
      ld_valid = 1'b0; instr_valid = 1'b0;
      chk("add_wb_valid", wb_valid, 1'b1);
      chk("add_wb_addr", wb_addr, 2'd0);
      chk("add_wb_data", wb_data, 8'h10);
      chk("add_wb_alu_op", alu_op, OP_NOP);
      tick();
      chk("add_flags", {flag_z, flag_c}, 2'b01);
      chk("add_idle_wb", wb_valid, 1'b0);

      // MOV leaves flags alone
      issue(mk(OP_MOV, 2'd3, 2'd0));
      chk("mov_exec_op", alu_op, OP_NOP);
      chk("mov_exec_a", alu_a, 8'h10);
      tick();
      chk("mov_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd3, 8'h10});
      tick();
      chk("mov_flags", {flag_z, flag_c}, 2'b01);

      // R3 holds the moved value, R1 was not touched while busy
      issue(mk(OP_OR, 2'd3, 2'd1));
      chk("or_exec_ab", {alu_a, alu_b}, 16'h1020);
      tick();
      chk("or_wb_data", wb_data, 8'h30);
      tick();
      chk("or_flags", {flag_z, flag_c}, 2'b00);

      // SUB to zero then JZ / JC
      preload(2'd2, 8'h55);
      preload(2'd3, 8'h55);
      issue(mk(OP_SUB, 2'd2, 2'd3));
      chk("sub_exec_op", alu_op, OP_SUB);
      tick();
      chk("sub_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd2, 8'h00});
      tick();
      chk("sub_flags", {flag_z, flag_c}, 2'b10);
      issue(mk(OP_JZ, 2'd0, 2'd0));
      chk("jz_exec_op", alu_op, OP_NOP);
      chk("jz_exec_branch", branch_taken, 1'b0);
      tick();
      chk("jz_wb_branch", branch_taken, 1'b1);
      chk("jz_wb_valid", wb_valid, 1'b0);
      tick();
      chk("jz_after_branch", branch_taken, 1'b0);
      issue(mk(OP_JC, 2'd0, 2'd0));
      tick();
      chk("jc_not_taken", {branch_taken, wb_valid}, 2'b00);
      tick();

      // Simultaneous preload and INC
      ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'h07;
      issue(mk(OP_INC, 2'd1, 2'd0));
      ld_valid = 1'b0;
      chk("inc_exec", {alu_op, alu_a}, {OP_INC, 8'h07});
      tick();
      chk("inc_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd1, 8'h08});
      tick();

      // DEC wraps 00 -> FF
      preload(2'd0, 8'h00);
      issue(mk(OP_DEC, 2'd0, 2'd0));
      tick();
      chk("dec_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd0, 8'hFF});
      tick();
      chk("dec_flags", {flag_z, flag_c}, 2'b00);

      // NOP opcode: no writeback, flags kept
      preload(2'd2, 8'h00);
      issue(8'hF5);
      chk("nop_exec_op", alu_op, OP_NOP);
      tick();
      chk("nop_wb", {wb_valid, branch_taken}, 2'b00);
      tick();
      chk("nop_flags", {flag_z, flag_c}, 2'b00);

      // Reset during EXEC of ADD R2 += R1
      issue(mk(OP_ADD, 2'd2, 2'd1));
      chk("rmid_exec_op", alu_op, OP_ADD);
      rst = 1'b1;
      #1;
      chk("rmid_alu_op", alu_op, 4'h7);
      chk("rmid_ready", instr_ready, 1'b1);
      tick();
      chk("rmid_wb_valid", wb_valid, 1'b0);
      rst = 1'b0;
      chk("rmid_rel_ready", instr_ready, 1'b1);
      tick();
      chk("rmid_idle_wb", wb_valid, 1'b0);
      issue(mk(OP_OR, 2'd2, 2'd2));
      chk("rmid_r2_zero", alu_a, 8'h00);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
